onchip_ram_burst: RTL and testbench
===================================

Name: onchip_ram_burst

Overview:
Parametrised successor to the single-port Nios on-chip RAM: a byte-enabled, single-clock Avalon-MM slave memory with pipelined reads and readdatavalid. It adds waitrequest flow control, linear read/write bursts, an optional output register stage, and an optional zero-fill sweep after reset. It sits on the Nios data/instruction interconnect as general-purpose scratch or program RAM.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 12, word address width; depth = 2**ADDR_WIDTH.
MAX_BURST, 8, maximum burst length in beats; power of 2, at least 1.
OUTPUT_REG, 0, 1 adds a registered read-data stage.
CLEAR_ON_RESET, 1, 1 enables the zero-fill sweep after reset.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
reset_req  in  1  reset-request; while high, clock enable is gated off.
clken  in  1  global clock enable.
address  in  ADDR_WIDTH  word address; sampled on the first beat only.
chipselect  in  1  slave select.
read  in  1  read command.
write  in  1  write command or write beat.
byteenable  in  DATA_WIDTH/8  per-byte write enable.
writedata  in  DATA_WIDTH  write data.
burstcount  in  clog2(MAX_BURST)+1  burst length in beats.
waitrequest  out  1  high means the command or beat is not accepted this cycle.
readdata  out  DATA_WIDTH  read data.
readdatavalid  out  1  readdata valid this cycle.
init_done  out  1  high once the memory is usable.

Behaviour:
- en = clken & ~reset_req. When en is low, all state, counters and the read pipeline hold, and waitrequest is 1.
- Reset (reset_n low, asynchronous): all outputs return to their reset values, and any burst or pending reads are discarded without a readdatavalid.
  - Reset values: waitrequest=1, readdatavalid=0, readdata=0, init_done=0, state=CLEAR (or IDLE with init_done=1 if CLEAR_ON_RESET=0).
  - Memory contents are not touched by reset itself.
- States: CLEAR, IDLE, RD_BURST, WR_BURST.
- CLEAR:
  - One word per en cycle is written with all-zero data and all bytes enabled, at addresses 0 to depth-1.
  - After the last word: init_done=1 and state goes to IDLE.
  - waitrequest=1 throughout CLEAR.
- IDLE:
  - waitrequest = ~en.
  - A command is accepted when chipselect & (read | write) & en.
  - Effective length len = burstcount clamped to the range 1..MAX_BURST (0 is treated as 1).
  - If read and write are both high, the command is treated as a write and the read is ignored.
- Write:
  - The first beat is written immediately at address.
  - If len > 1: go to WR_BURST, where each further beat is accepted when chipselect & write & en, at an internally incremented address.
  - Cycles with write low in WR_BURST are idle (no write). waitrequest=~en in WR_BURST.
  - Return to IDLE after beat len is written.
  - Only bytes with byteenable high are modified.
- Read:
  - Beat 0 is issued in the accept cycle.
  - If len > 1: go to RD_BURST, which issues one read per en cycle at incremented addresses, with waitrequest=1 (no new command accepted).
  - Return to IDLE in the cycle the last beat is issued, so a new command is accepted in the following cycle.
  - Back-to-back single reads are sustained at 1 per cycle.
- Read latency: readdatavalid is asserted 1+OUTPUT_REG en-cycles after the issue cycle, one pulse per beat, in order.
- Address wrap: the burst address increments modulo depth, so (depth-1)+1 = 0.
- Read-after-write: a read issued in the cycle after a write to the same address returns the new data.
- Read and write in the same cycle to the same address cannot occur (single port, one command per cycle).

Decomposition:
- Package onchip_ram_pkg holds:
  - the state enum (CLEAR, IDLE, RD_BURST, WR_BURST);
  - a localparam function for the burstcount width (clog2(MAX_BURST)+1);
  - the byte-lane count constant DATA_WIDTH/8.
- Sub-module onchip_ram_core: inferred single-port byte-enabled RAM with a 1-cycle synchronous read and a clock enable; no reset on the array.
- The top level contains the FSM, burst counter, address incrementer, read-valid shift pipeline and optional output register.

Test Plan:
1. CLEAR sweep (ADDR_WIDTH=4, CLEAR_ON_RESET=1): release reset_n -> init_done rises exactly 16 en-cycles later; every address then reads 0x00000000.
2. Byte-enable write: write 0xAABBCCDD at address 5 with byteenable=0b1111, then write 0x11223344 with byteenable=0b0101 -> reading address 5 returns 0xAA22CC44 with readdatavalid 1 cycle after issue (OUTPUT_REG=0) or 2 cycles after issue (OUTPUT_REG=1).
3. Wrapping burst: write burst len=4 at address 14 with data 1,2,3,4 (depth 16), then read burst len=4 from address 14 -> readdata sequence 1,2,3,4 (addresses 14,15,0,1); waitrequest high for 3 cycles after the read is accepted.
4. Clamp and stall: burstcount=15 with MAX_BURST=8 -> exactly 8 readdatavalid pulses. Dropping clken for 3 cycles mid-burst freezes readdatavalid and the address; the burst resumes with no lost or duplicated beats.
5. Reset mid-operation: assert reset_n low in the middle of a read burst -> readdatavalid=0 and waitrequest=1 immediately; after release, the CLEAR sweep reruns and no stale readdatavalid pulses appear.
6. Priority and reset_req: read=write=1 at address 3 with writedata 0x5A -> the word is written and no readdatavalid is produced; reset_req=1 -> waitrequest=1 and no memory access occurs.

Source files
------------

// File: rtl/onchip_ram_burst_pkg.sv
// Shared types and sizing helpers for the burst-capable on-chip RAM.
// Imported by the bus interface, the RAM core and the top level.
package onchip_ram_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    RD_BURST,
    WR_BURST
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LANES      = DEF_DATA_WIDTH / 8;

  function automatic int bc_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  function automatic int lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/onchip_ram_burst_if.sv
// Avalon-MM burst slave bundle for the on-chip RAM.
// The master modport drives commands; the slave modport answers them.
interface onchip_ram_burst_if
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int BC_WIDTH   = 4
);

  logic [ADDR_WIDTH-1:0]        address;
  logic                         chipselect;
  logic                         read;
  logic                         write;
  logic [lanes(DATA_WIDTH)-1:0] byteenable;
  logic [DATA_WIDTH-1:0]        writedata;
  logic [BC_WIDTH-1:0]          burstcount;
  logic                         waitrequest;
  logic [DATA_WIDTH-1:0]        readdata;
  logic                         readdatavalid;

  modport master (
    output address, chipselect, read, write,
    output byteenable, writedata, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write,
    input  byteenable, writedata, burstcount,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/onchip_ram_burst_core.sv
// Single-port byte-enabled RAM, synchronous read, clock enabled.
// The array is never reset; contents survive reset_n.
module onchip_ram_core
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [lanes(DATA_WIDTH)-1:0] be,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);

  localparam int LANES = lanes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Read-before-write within a cycle; next-cycle reads see new data
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we && be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/onchip_ram_burst.sv
// Avalon-MM burst RAM slave: FSM, burst counter, address
// incrementer, read-valid pipeline and optional output register.
module onchip_ram_burst
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int MAX_BURST      = 8,
  parameter int OUTPUT_REG     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               reset_req,
  input  logic               clken,
  onchip_ram_burst_if.slave  bus,
  output logic               init_done
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int BCW   = bc_width(MAX_BURST);
  localparam int LANES = lanes(DATA_WIDTH);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [BCW-1:0]        cnt_t;

  state_t                state;
  addr_t                 addr_q;
  cnt_t                  cnt;
  cnt_t                  len;
  logic                  en;
  logic                  accept;
  logic                  wr_beat;
  logic                  clr_beat;
  logic                  rd_issue;
  logic                  rv1;
  logic                  mem_we;
  logic [LANES-1:0]      mem_be;
  addr_t                 mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rdata;

  assign en = clken & ~reset_req;

  always_comb begin
    len = bus.burstcount;
    if (bus.burstcount == '0) begin
      len = cnt_t'(1);
    end else if (bus.burstcount > cnt_t'(MAX_BURST)) begin
      len = cnt_t'(MAX_BURST);
    end
  end

  // Write wins when read and write arrive together
  assign accept = en && state == IDLE && bus.chipselect
               && (bus.read || bus.write);
  assign wr_beat = en && ((accept && bus.write)
               || (state == WR_BURST && bus.chipselect
                   && bus.write));
  assign clr_beat = en && state == CLEAR;
  assign rd_issue = en && ((accept && !bus.write)
               || state == RD_BURST);

  assign mem_we    = wr_beat | clr_beat;
  assign mem_be    = clr_beat ? '1 : bus.byteenable;
  assign mem_wdata = clr_beat ? '0 : bus.writedata;
  assign mem_addr  = (state == IDLE) ? bus.address : addr_q;

  assign bus.waitrequest = !reset_n || !en
                        || state == CLEAR || state == RD_BURST;

  onchip_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .en    (en),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      init_done <= (CLEAR_ON_RESET == 0);
      addr_q    <= '0;
      cnt       <= '0;
    end else if (en) begin
      unique case (state)
        CLEAR: begin
          addr_q <= addr_q + 1'b1;
          if (addr_q == addr_t'(DEPTH - 1)) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            addr_q <= bus.address + 1'b1;
            cnt    <= len - 1'b1;
            if (len > cnt_t'(1)) begin
              state <= bus.write ? WR_BURST : RD_BURST;
            end
          end
        end
        RD_BURST: begin
          addr_q <= addr_q + 1'b1;
          cnt    <= cnt - 1'b1;
          if (cnt == cnt_t'(1)) state <= IDLE;
        end
        WR_BURST: begin
          if (bus.chipselect && bus.write) begin
            addr_q <= addr_q + 1'b1;
            cnt    <= cnt - 1'b1;
            if (cnt == cnt_t'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv1 <= 1'b0;
    end else if (en) begin
      rv1 <= rd_issue;
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic                  rv2;
      logic [DATA_WIDTH-1:0] rd_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rv2  <= 1'b0;
          rd_q <= '0;
        end else if (en) begin
          rv2 <= rv1;
          if (rv1) rd_q <= rdata;
        end
      end

      assign bus.readdatavalid = rv2;
      assign bus.readdata      = rd_q;
    end else begin : g_noreg
      // Zero when idle so readdata is defined straight out of reset
      assign bus.readdatavalid = rv1;
      assign bus.readdata      = rdata & {DATA_WIDTH{rv1}};
    end
  endgenerate

endmodule

// File: tb/tb_onchip_ram_burst.sv
// Bench for onchip_ram_burst: two instances (with and without the
// output register) share stimulus and a word-array reference model.
module tb_onchip_ram_burst;
  import onchip_ram_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int MB    = 8;
  localparam int BW    = bc_width(MB);
  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic reset_req = 1'b0;
  logic clken     = 1'b1;
  logic init0;
  logic init1;
  logic en;
  bit   rnd = 1'b0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem [DEPTH];
  int          ec       = 0;
  int          n_assert = 0;
  int          n_fail   = 0;

  assign en = clken & ~reset_req;
  always #5 clk = ~clk;

  onchip_ram_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BC_WIDTH(BW)) b0();
  onchip_ram_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BC_WIDTH(BW)) b1();

  onchip_ram_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB),
    .OUTPUT_REG(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
    .clken(clken), .bus(b0.slave), .init_done(init0)
  );

  onchip_ram_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB),
    .OUTPUT_REG(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
    .clken(clken), .bus(b1.slave), .init_done(init1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // En-cycle index; a beat issued at en-edge k is sampled at k+1+OUTPUT_REG
  always @(posedge clk) if (en) ec++;

  always @(negedge clk) begin
    if (!en) chk("stall_wait0", 32'(b0.waitrequest), 32'd1);
    if (!en) chk("stall_wait1", 32'(b1.waitrequest), 32'd1);
    if (en) begin
      bit e0;
      bit e1;
      e0 = q0.size() > 0 && q0[0].due == ec + 1;
      e1 = q1.size() > 0 && q1[0].due == ec + 1;
      chk("rdv0", 32'(b0.readdatavalid), 32'(e0));
      chk("rdv1", 32'(b1.readdatavalid), 32'(e1));
      if (e0) begin
        chk("rdata0", b0.readdata, q0[0].d);
        void'(q0.pop_front());
      end
      if (e1) begin
        chk("rdata1", b1.readdata, q1[0].d);
        void'(q1.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rnd) begin
      #1;
      clken     = ($urandom % 6) != 0;
      reset_req = ($urandom % 20) == 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input bit cs, input bit rd, input bit wr,
                         input logic [3:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic [3:0] bc);
    b0.chipselect = cs; b1.chipselect = cs;
    b0.read = rd;       b1.read = rd;
    b0.write = wr;      b1.write = wr;
    b0.address = a;     b1.address = a;
    b0.byteenable = be; b1.byteenable = be;
    b0.writedata = wd;  b1.writedata = wd;
    b0.burstcount = bc; b1.burstcount = bc;
  endtask

  task automatic idle_bus();
    set_bus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 4'd1);
  endtask

  task automatic merge(input int a, input logic [3:0] be,
                       input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (be[b]) mem[a % DEPTH][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic wait_acc(input string tag, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (en && !b0.waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s_timeout observed=%0d expected=1", tag, ok);
    end
    if (ok) chk({tag, "_acc1"}, 32'(b1.waitrequest), 32'd0);
  endtask

  task automatic xfer(input string tag, input bit rd, input bit wr,
                      input logic [3:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [3:0] bc,
                      input bit gaps);
    int L;
    int k;
    bit ok;
    L = (bc == 0) ? 1 : ((int'(bc) > MB) ? MB : int'(bc));
    set_bus(1'b1, rd, wr, a, be, wd, bc);
    wait_acc(tag, ok);
    if (!ok) begin
      idle_bus();
      return;
    end
    k = ec + 1;
    if (wr) begin
      merge(int'(a), be, wd);
      step();
      for (int i = 1; i < L; i++) begin
        if (gaps && ($urandom % 3) == 0) begin
          set_bus(1'b1, 1'b0, 1'b0, ~a, be, 32'hDEAD_BEEF, bc);
          step();
        end
        set_bus(1'b1, 1'b0, 1'b1, ~a, be, wd + 32'(i), bc);
        wait_acc(tag, ok);
        if (!ok) break;
        merge(int'(a) + i, be, wd + 32'(i));
        step();
      end
    end else begin
      for (int i = 0; i < L; i++) begin
        q0.push_back('{mem[(int'(a) + i) % DEPTH], k + i + 1});
        q1.push_back('{mem[(int'(a) + i) % DEPTH], k + i + 2});
      end
      step();
    end
    idle_bus();
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 200 && (q0.size() + q1.size()) != 0; t++) step();
    chk({tag, "_left0"}, 32'(q0.size()), 32'd0);
    chk({tag, "_left1"}, 32'(q1.size()), 32'd0);
  endtask

  task automatic release_and_clear(input string tag);
    int e0;
    reset_n = 1'b1;
    e0 = ec;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (init0) break;
    end
    n_assert++;
    assert (init0) else begin
      n_fail++;
      $error("FAIL %s_init observed=%0d expected=1", tag, init0);
    end
    chk({tag, "_init_cycles"}, 32'(ec - e0), 32'd16);
    chk({tag, "_init1"}, 32'(init1), 32'd1);
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    step();
  endtask

  initial begin
    idle_bus();
    step();
    step();
    @(negedge clk);
    chk("rst_wait0", 32'(b0.waitrequest), 32'd1);
    chk("rst_wait1", 32'(b1.waitrequest), 32'd1);
    chk("rst_rdv0", 32'(b0.readdatavalid), 32'd0);
    chk("rst_rd1", b1.readdata, 32'd0);
    chk("rst_init0", 32'(init0), 32'd0);
    step();

    // Zero-fill sweep, then read everything back
    release_and_clear("clr");
    xfer("rd_lo", 1, 0, 4'd0, 4'hF, 0, 4'd8, 0);
    xfer("rd_hi", 1, 0, 4'd8, 4'hF, 0, 4'd8, 0);
    drain("clr");

    // Byte enables with read-after-write in the next cycle
    xfer("be_full", 0, 1, 4'd5, 4'hF, 32'hAABB_CCDD, 4'd1, 0);
    xfer("be_part", 0, 1, 4'd5, 4'b0101, 32'h1122_3344, 4'd1, 0);
    xfer("be_rd", 1, 0, 4'd5, 4'hF, 0, 4'd1, 0);
    drain("be");

    // Wrapping bursts and waitrequest during a read burst
    xfer("wrap_wr", 0, 1, 4'd14, 4'hF, 32'd1, 4'd4, 0);
    xfer("wrap_rd", 1, 0, 4'd14, 4'hF, 0, 4'd4, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_wait", 32'(b0.waitrequest), 32'(i < 3));
    end
    step();
    drain("wrap");

    // Clamped burst with a clken stall in the middle
    xfer("clamp_rd", 1, 0, 4'd2, 4'hF, 0, 4'd15, 0);
    step();
    clken = 1'b0;
    step(); step(); step();
    clken = 1'b1;
    drain("clamp");

    // Back-to-back single reads
    for (int i = 0; i < 4; i++)
      xfer("b2b", 1, 0, 4'(i + 13), 4'hF, 0, 4'd0, 0);
    drain("b2b");

    // Reset in the middle of a read burst
    xfer("pre_rst", 0, 1, 4'd0, 4'hF, 32'h0BAD_0000, 4'd8, 0);
    xfer("mid_rd", 1, 0, 4'd0, 4'hF, 0, 4'd8, 0);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("arst_rdv0", 32'(b0.readdatavalid), 32'd0);
    chk("arst_rdv1", 32'(b1.readdatavalid), 32'd0);
    chk("arst_wait", 32'(b0.waitrequest), 32'd1);
    q0.delete();
    q1.delete();
    step();
    step();
    release_and_clear("reclr");
    xfer("post_rst", 1, 0, 4'd0, 4'hF, 0, 4'd8, 0);
    drain("post_rst");

    // Read+write together is a write; reset_req blocks access
    xfer("prio", 1, 1, 4'd3, 4'hF, 32'h0000_005A, 4'd1, 0);
    step();
    reset_req = 1'b1;
    set_bus(1'b1, 1'b0, 1'b1, 4'd3, 4'hF, 32'hDEAD_BEEF, 4'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rreq_wait", 32'(b0.waitrequest), 32'd1);
    end
    step();
    idle_bus();
    reset_req = 1'b0;
    xfer("prio_rd", 1, 0, 4'd3, 4'hF, 0, 4'd1, 0);
    drain("prio");

    // Random traffic under random clken / reset_req stalls
    rnd = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int op;
      op = int'($urandom % 3);
      xfer("rand", op != 1, op != 0, 4'($urandom), 4'($urandom),
           $urandom, 4'($urandom), 1);
    end
    rnd = 1'b0;
    @(posedge clk);
    #2;
    clken = 1'b1;
    reset_req = 1'b0;
    drain("rand");
    for (int a = 0; a < DEPTH; a += 8)
      xfer("final_rd", 1, 0, 4'(a), 4'hF, 0, 4'd8, 0);
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
